// File: rtl/multibyte_add_sequencer.sv
// ---------------------------------------------------------------------------
// multibyte_add_sequencer
//
// Multi-precision add/subtract controller. One shared 8-bit full-add cell is
// stepped over NBYTES cycles, least-significant byte first. The inter-byte
// carry is held in a register, so no wide ripple chain is ever built.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - operation request, sampled only while idle
//   sub       - 0: A + B + carry_in, 1: A - B (carry_in ignored)
//   carry_in  - initial carry for add
//   op_a      - operand A (8*NBYTES bits), sampled with start
//   op_b      - operand B (8*NBYTES bits), sampled with start
//   busy      - high while byte steps are in progress
//   done      - one-cycle completion pulse
//   result    - sum / difference (valid once done has pulsed)
//   carry_out - final byte carry (subtract: 1 = no borrow)
//   overflow  - two's-complement overflow of the full-width operation
// ---------------------------------------------------------------------------
module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  carry_in,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  overflow
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;   // holds ~op_b for subtract

    logic [W-1:0]    a_shift_s;
    logic [W-1:0]    b_shift_s;
    logic [7:0]      a_byte_s;
    logic [7:0]      b_byte_s;
    logic [8:0]      add_s;
    logic            ovf_s;

    // The shared 8-bit full-add cell: {carry, sum}.
    function automatic logic [8:0] byte_add(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic       ci);
        byte_add = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    endfunction

    // Byte selection from the operand registers; the adder is fed only from
    // registers so its inputs are stable for the whole cycle.
    assign a_shift_s = a_r >> {idx_r, 3'b000};
    assign b_shift_s = b_r >> {idx_r, 3'b000};
    assign a_byte_s  = a_shift_s[7:0];
    assign b_byte_s  = b_shift_s[7:0];
    assign add_s     = byte_add(a_byte_s, b_byte_s, carry_r);

    // Signed overflow: operands of equal sign producing a sum of the other
    // sign. Only meaningful on the last step, where add_s[7] is the result MSB.
    assign ovf_s = (a_r[W-1] == b_r[W-1]) && (add_s[7] != a_r[W-1]);

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r     <= op_a;
                        b_r     <= sub ? ~op_b : op_b;
                        carry_r <= sub ? 1'b1 : carry_in;
                        idx_r   <= '0;
                        state_r <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    result[{idx_r, 3'b000} +: 8] <= add_s[7:0];
                    carry_r <= add_s[8];
                    if (idx_r == IDX_LAST) begin
                        idx_r     <= '0;
                        state_r   <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        carry_out <= add_s[8];
                        overflow  <= ovf_s;
                    end else begin
                        idx_r <= idx_r + IW'(1);
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    idx_r   <= '0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multibyte_add_sequencer
//
// Directed self-checking bench for multibyte_add_sequencer with NBYTES=4.
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_multibyte_add_sequencer;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          sub;
    logic          carry_in;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          carry_out;
    logic          overflow;

    int            checks_cnt;
    int            errors_cnt;
    int            consec_cnt;
    logic          done_prev;

    multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .carry_in  (carry_in),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Track back-to-back done pulses.
    initial begin
        consec_cnt = 0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (done && done_prev) consec_cnt++;
            done_prev = done;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present an operation and hold start across one rising edge (E0).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ci);
        op_a     = a;
        op_b     = b;
        sub      = s;
        carry_in = ci;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
    endtask

    // Wait (bounded) for done; returns edges waited and busy samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = busy ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (busy) bcnt++;
        end
    endtask

    // Full operation with latency, busy-length and result checks.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic ci, input logic [W-1:0] exp_res,
                          input logic exp_co, input logic exp_ov);
        int lat;
        int bcnt;
        issue(a, b, s, ci);
        wait_done(lat, bcnt);
        check_val({tag, "_lat"},  64'(lat), 64'd4);
        check_val({tag, "_busy"}, 64'(bcnt), 64'd4);
        check_val({tag, "_bend"}, 64'(busy), 64'd0);
        check_val({tag, "_res"},  64'(result), 64'(exp_res));
        check_val({tag, "_co"},   64'(carry_out), 64'(exp_co));
        check_val({tag, "_ov"},   64'(overflow), 64'(exp_ov));
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        sub      = 1'b0;
        carry_in = 1'b0;
        op_a     = '0;
        op_b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_res",  64'(result), 64'd0);
        check_val("rst_co",   64'(carry_out), 64'd0);
        check_val("rst_ov",   64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add, full ripple, subtracts, signed overflow
        run_op("add_byte",  32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op("ripple",    32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
        run_op("sub_borrow",32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
        run_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // Start re-pulsed while busy must be ignored
        issue(32'h01020304, 32'h10203040, 1'b0, 1'b0);
        op_a  = 32'hFFFFFFFF;
        op_b  = 32'hFFFFFFFF;
        sub   = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        // Two edges already elapsed after E0, so done arrives two edges later.
        check_val("ign_lat", 64'(lat), 64'd2);
        check_val("ign_res", 64'(result), 64'h11223344);
        check_val("ign_co",  64'(carry_out), 64'd0);
        check_val("ign_ov",  64'(overflow), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check_val("ign_nodone", 64'(dcnt), 64'd0);

        // Start held high through the done cycle: back-to-back operation
        issue(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        check_val("b2b1_lat", 64'(lat), 64'd4);
        check_val("b2b1_res", 64'(result), 64'h00000030);
        issue(32'h00000100, 32'h00000001, 1'b1, 1'b0);
        check_val("b2b_done_low", 64'(done), 64'd0);
        check_val("b2b_busy",     64'(busy), 64'd1);
        wait_done(lat, bcnt);
        check_val("b2b2_lat", 64'(lat), 64'd4);
        check_val("b2b2_res", 64'(result), 64'h000000FF);
        check_val("b2b2_co",  64'(carry_out), 64'd1);
        check_val("b2b2_ov",  64'(overflow), 64'd0);

        // Reset two cycles into an operation: outputs clear without a clock
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        check_val("mid_rst_done", 64'(done), 64'd0);
        check_val("mid_rst_res",  64'(result), 64'd0);
        check_val("mid_rst_co",   64'(carry_out), 64'd0);
        check_val("mid_rst_ov",   64'(overflow), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check_val("mid_rst_nodone", 64'(dcnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

        check_val("done_consec", 64'(consec_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
